// File: rtl/ic_backup_ctrl.sv
// Checkpoint/restore sequencer that moves tracked register contents to and from NVM.
// Define BACKUP_SKIP_CLEAN_EN to back up only dirty registers; otherwise every register is written.
module ic_backup_ctrl #(
  parameter int unsigned N  = 32,
  parameter int unsigned R  = 8,
  parameter int unsigned AW = $clog2(R)
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           Pwr_off,
  input  logic           Backup_req,
  input  logic           Restore_req,
  input  logic [2*R-1:0] Dirty_vals,
  input  logic [N*R-1:0] Backup_Vouts,
  output logic [R-1:0]   Backup_en,
  output logic [R-1:0]   Backup_ack,
  output logic [R-1:0]   Restore_en,
  output logic [N-1:0]   Restore_Vin,
  output logic           Nvm_req,
  output logic           Nvm_we,
  output logic [AW-1:0]  Nvm_addr,
  output logic [N-1:0]   Nvm_wdata,
  input  logic [N-1:0]   Nvm_rdata,
  input  logic           Nvm_ack,
  output logic           Busy,
  output logic           Done
);

  typedef enum logic [2:0] {
    StIdle, StScan, StCapt, StWrite, StBack, StRd, StLoad, StFin
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  dbuf_q, dbuf_d;
  logic          last_idx;
  logic          needs_backup;
  logic [N-1:0]  vouts [R];

  for (genvar i = 0; i < R; i++) begin : g_vouts
    assign vouts[i] = Backup_Vouts[N*i +: N];
  end

  assign last_idx = (idx_q == AW'(R - 1));

`ifdef BACKUP_SKIP_CLEAN_EN
  // Bit 0 of each dirty pair covers both "dirty" and "written during backup".
  assign needs_backup = Dirty_vals[{idx_q, 1'b0}];
`else
  logic unused_dirty;
  assign unused_dirty = ^Dirty_vals;
  assign needs_backup = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dbuf_d      = dbuf_q;
    Backup_en   = '0;
    Backup_ack  = '0;
    Restore_en  = '0;
    Restore_Vin = '0;
    Nvm_req     = 1'b0;
    Nvm_we      = 1'b0;
    Nvm_addr    = '0;
    Nvm_wdata   = '0;
    Done        = 1'b0;
    Busy        = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        idx_d = '0;
        if (Restore_req) begin
          state_d = StRd;
        end else if (Backup_req) begin
          state_d = StScan;
        end
      end
      StScan: begin
        if (needs_backup) begin
          state_d = StCapt;
        end else if (last_idx) begin
          state_d = StFin;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StCapt: begin
        Backup_en[idx_q] = 1'b1;
        dbuf_d           = vouts[idx_q];
        state_d          = StWrite;
      end
      StWrite: begin
        Nvm_req   = 1'b1;
        Nvm_we    = 1'b1;
        Nvm_addr  = idx_q;
        Nvm_wdata = dbuf_q;
        if (Nvm_ack) begin
          state_d = StBack;
        end
      end
      StBack: begin
        Backup_ack[idx_q] = 1'b1;
        if (last_idx) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = StScan;
        end
      end
      StRd: begin
        Nvm_req  = 1'b1;
        Nvm_addr = idx_q;
        if (Nvm_ack) begin
          dbuf_d  = Nvm_rdata;
          state_d = StLoad;
        end
      end
      StLoad: begin
        Restore_en[idx_q] = 1'b1;
        Restore_Vin       = dbuf_q;
        if (last_idx) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = StRd;
        end
      end
      StFin: begin
        Done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Power loss kills the sequence and every strobe in the same cycle.
    if (Pwr_off) begin
      state_d     = StIdle;
      idx_d       = '0;
      dbuf_d      = dbuf_q;
      Backup_en   = '0;
      Backup_ack  = '0;
      Restore_en  = '0;
      Restore_Vin = '0;
      Nvm_req     = 1'b0;
      Nvm_we      = 1'b0;
      Nvm_addr    = '0;
      Nvm_wdata   = '0;
      Done        = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      dbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dbuf_q  <= dbuf_d;
    end
  end

endmodule

// File: doc/ic_backup_ctrl.md
# ic_backup_ctrl

Checkpoint/restore sequencer for the intermittent-computing register file. It watches the 2-bit dirty state of R dirty-tracked registers and, on a backup request, copies each dirty register's backup output into non-volatile memory (NVM) over a req/ack port, then acknowledges that register. On a restore request it reads all R words back from NVM and drives them into the registers one at a time through their restore inputs.

## Interface
- N, 32, data width of each register and NVM word
- R, 8, number of tracked registers (≥2); NVM address of register i is i
- AW, $clog2(R), NVM address width
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-low reset
- Pwr_off  in  1  power-loss simulation; synchronous abort
- Backup_req  in  1  checkpoint trigger, sampled only in IDLE
- Restore_req  in  1  restore trigger, sampled only in IDLE
- Dirty_vals  in  2*R  Dirty_val of register i at bits [2i+1:2i]
- Backup_Vouts  in  N*R  backup output of register i at bits [N*i+N-1:N*i]
- Backup_en  out  R  one-hot, backup start strobe to register i
- Backup_ack  out  R  one-hot, backup completion strobe to register i
- Restore_en  out  R  one-hot, restore load strobe to register i
- Restore_Vin  out  N  restore data, shared by all registers
- Nvm_req  out  1  NVM transfer request
- Nvm_we  out  1  1 = write, 0 = read
- Nvm_addr  out  AW  NVM word address
- Nvm_wdata  out  N  NVM write data
- Nvm_rdata  in  N  NVM read data, valid with Nvm_ack on reads
- Nvm_ack  in  1  NVM transfer complete
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse when a full backup or restore sequence completes

## Operation
- Dirty encoding: 00 clean, 01 dirty, 10 backup in progress, 11 written during backup. Register needs backup iff Dirty_val[0]=1.
- States: IDLE, SCAN, CAPT, WRITE, BACK, RD, LOAD, FIN. Index register idx (AW bits), data register dbuf (N bits).
- IDLE: idx←0. Restore_req → RD (priority over Backup_req). Else Backup_req → SCAN.
- SCAN (one cycle per idx): needs backup → CAPT; else if idx=R-1 → FIN, else idx++ and stay.
- CAPT (1 cycle): Backup_en[idx]=1; dbuf←Backup_Vouts[idx] → WRITE.
- WRITE: Nvm_req=1, Nvm_we=1, Nvm_addr=idx, Nvm_wdata=dbuf held stable; on Nvm_ack → BACK.
- BACK (1 cycle): Backup_ack[idx]=1; idx=R-1 → FIN, else idx++ → SCAN.
- RD: Nvm_req=1, Nvm_we=0, Nvm_addr=idx; on Nvm_ack dbuf←Nvm_rdata → LOAD.
- LOAD (1 cycle): Restore_en[idx]=1, Restore_Vin=dbuf; idx=R-1 → FIN, else idx++ → RD.
- FIN (1 cycle): Done=1 → IDLE.
- Requests arriving while Busy are ignored (not queued).
- Pwr_off=1 in any state: next state IDLE, idx←0, no Done; all strobes and Nvm_req low in that cycle (combinational gating).
- Restore_Vin=dbuf only in LOAD, else 0. Nvm_wdata/Nvm_addr 0 when Nvm_req=0.

## Timing
- Reset: state IDLE, idx 0, dbuf 0; every output 0.
- Nvm_req asserts on entry to WRITE/RD, stays high through the ack cycle, deasserts next cycle; ack in first WRITE/RD cycle is legal. Nvm_ack outside WRITE/RD is ignored.
- Dirty register cost: 1 SCAN + 1 CAPT + (L+1) WRITE + 1 BACK, L = cycles from req to ack.
- Clean register cost: 1 SCAN cycle.
- Restore per register: (L+1) RD + 1 LOAD. Done one cycle after final BACK/LOAD/SCAN.
- Dirty_vals sampled only in SCAN; changes after CAPT do not affect the in-flight register.
- Reset mid-sequence: immediate return to reset values regardless of NVM handshake.

## Configuration
- BACKUP_SKIP_CLEAN_EN defined: SCAN skips clean registers as above.
- Undefined: every register treated as needing backup; SCAN always goes to CAPT (full checkpoint, R NVM writes).

## Test plan
- Reset: R=4, drive Rst=0 mid-WRITE with Nvm_req=1 → all outputs 0 immediately, IDLE after release.
- Backup, skip enabled: R=4, Dirty_vals=8'b00_01_00_11, L=2 → writes only addr 0 and 2, Backup_en/ack pulse on bits 0 and 2, Done 1 cycle later, 14 cycles total from SCAN.
- Backup, skip disabled: same stimulus → 4 writes, addr 0..3, data equals Backup_Vouts slices.
- Restore: NVM holds 0xA5A5_0000+i, L=0 → Restore_en one-hot 0..3 with Restore_Vin=0xA5A5_0000..0003, then Done.
- Simultaneous Restore_req and Backup_req in IDLE → restore runs; Backup_req held during run ignored.
- Pwr_off=1 during WRITE of idx 1 → Nvm_req drops same cycle, no Backup_ack[1], no Done, IDLE next cycle; new Backup_req restarts at idx 0.
